data_mem_master: RTL and testbench
==================================

Name: data_mem_master

Overview:
- Load/store initiator between the 16-bit CPU datapath and the byte-organised, big-endian data memory.
- The memory exposes a 16-bit byte address, a combinational (same-cycle) read byte and a write byte committed on the rising clock edge.
- The block accepts one word or byte request per handshake. It splits a word into two byte transactions: high byte at A, low byte at A+1.
- It range-checks the address, then returns the load data or a fault with a one-cycle Done pulse.

Parameters:
- MEM_BYTES, 128, number of addressable bytes. Any byte address >= MEM_BYTES is out of range.

Ports:
- Clock    in   1   rising-edge clock
- Reset    in   1   synchronous, active-high reset
- Req      in   1   request valid; sampled only when Ready=1
- Op       in   2   00 LW (load word), 01 SW (store word), 10 LB (load byte, sign-extend), 11 SB (store byte, WData[7:0])
- Addr     in   16  byte address of the access (the high byte for words)
- WData    in   16  store data
- Ready    out  1   high only in IDLE and when Reset=0
- Done     out  1   one-cycle pulse, response valid
- Fault    out  1   valid with Done; 1 = address out of range, no memory access performed
- LoadData out  16  load result, registered, valid with Done, held until the next Done
- MemAddr  out  16  byte address to the data memory
- MemWData out  8   write byte to the data memory
- MemWE    out  1   byte write enable
- MemRE    out  1   read strobe, informational only
- MemRData in   8   combinational read byte for MemAddr

Behaviour:
- State machine: IDLE, ACC_HI, ACC_LO, RESP. Reset state is IDLE.
- Reset values: Done=0, Fault=0, LoadData=0x0000, MemWE=0, MemRE=0, MemAddr=0x0000, MemWData=0x00.
- Ready=1 from the first cycle after reset.
- Accept: at a rising edge with Req=1 and Ready=1, latch Op, Addr and WData.
  - Requester inputs may change after that edge.
  - Req in any other state is ignored and is never queued.
- Range check at accept, with 17-bit arithmetic so there is no wrap:
  - Word access: fault if Addr+1 >= MEM_BYTES.
  - Byte access: fault if Addr >= MEM_BYTES.
  - Fault path: IDLE -> RESP directly, with Fault=1 and LoadData=0x0000. No MemWE/MemRE is asserted.
  - Addr=0xFFFF word access faults; it must not wrap to 0x0000.
- IDLE -> ACC_HI on an in-range accept.
- ACC_HI:
  - MemAddr=A.
  - Loads: MemRE=1. MemRData is captured at the end of the cycle. LW captures into LoadData[15:8]; LB sign-extends into all 16 bits.
  - SW: MemWE=1, MemWData=WData[15:8].
  - SB: MemWE=1, MemWData=WData[7:0].
  - Next state: ACC_LO for LW/SW, RESP for LB/SB.
- ACC_LO:
  - MemAddr=A+1.
  - LW: MemRE=1, capture into LoadData[7:0].
  - SW: MemWE=1, MemWData=WData[7:0].
  - Next state: RESP.
- RESP: Done=1 for exactly one cycle, Fault as decided at accept. Next state: IDLE. Ready=0 during RESP.
- Latency from the accept edge to the Done cycle: word 3 cycles, byte 2, fault 1.
- Back-to-back issue interval: word 4 cycles, byte 3, fault 2.
- Mem outputs are 0 in IDLE and RESP. MemWE and MemRE are never both 1.
- Stores leave LoadData unchanged.
- Reset has priority in every state. Reset=1 forces IDLE at the next edge and clears all registered outputs.
- MemWE and MemRE are gated combinationally with ~Reset, so no memory write occurs in any cycle where Reset=1.
  - A store interrupted between ACC_HI and ACC_LO leaves only the high byte written, and Done is never raised.
- Req and Reset in the same cycle: Reset wins, and the request is not accepted.

Test Plan:
- LW in range:
  - Memory bytes [0x10]=0xAB, [0x11]=0xCD. Issue LW Addr=0x0010.
  - Required: MemAddr 0x0010 then 0x0011. Done on the 3rd cycle after the accept edge with LoadData=0xABCD, Fault=0.
- SW then LW:
  - SW Addr=0x0020 WData=0x1234.
  - Required: MemWE in 2 cycles, writing 0x12@0x20 then 0x34@0x21. A following LW 0x0020 returns 0x1234.
- LB sign extension and SB:
  - LB from a byte holding 0x80 -> LoadData=0xFF80. LB from a byte holding 0x7F -> 0x007F.
  - SB Addr=0x0005 WData=0xBEEF writes only 0xEF@0x05; bytes 0x04 and 0x06 are unchanged.
- Boundary faults (MEM_BYTES=128):
  - LW 0x007E succeeds.
  - LW 0x007F, LB 0x0080 and LW 0xFFFF each give Done+Fault=1 one cycle after accept, LoadData=0x0000, and no MemWE/MemRE pulse.
  - LB 0x007F succeeds.
- Handshake:
  - Hold Req=1 continuously with alternating ops.
  - Required: Ready only in IDLE, exactly one Done per accept, no accept during ACC_HI/ACC_LO/RESP.
- Reset mid-store:
  - Assert Reset in the ACC_LO cycle of SW 0x0030 WData=0xAA55.
  - Required: byte 0x30=0xAA, byte 0x31 unchanged, no Done, Ready=1 and all outputs at reset values in the cycle after reset deasserts.

Source files
------------

// File: rtl/data_mem_master.sv
// ============================================================================
//  Module   : data_mem_master
//  Purpose  : Load/store initiator between a 16-bit datapath and a byte-wide,
//             big-endian data memory with range checking and a Done pulse.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module data_mem_master #(
    parameter int MEM_BYTES = 128
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Req,
    input  logic [1:0]  Op,
    input  logic [15:0] Addr,
    input  logic [15:0] WData,
    output logic        Ready,
    output logic        Done,
    output logic        Fault,
    output logic [15:0] LoadData,
    output logic [15:0] MemAddr,
    output logic [7:0]  MemWData,
    output logic        MemWE,
    output logic        MemRE,
    input  logic [7:0]  MemRData
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACC_HI = 2'd1,
        S_ACC_LO = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    localparam logic [16:0] c_MEM_BYTES = 17'(MEM_BYTES);

    state_t      r_state;
    logic [1:0]  r_op;
    logic [15:0] r_addr;
    logic [15:0] r_wdata;
    logic        r_done;
    logic        r_fault;
    logic [15:0] r_loadData;
    logic [15:0] r_memAddr;
    logic [7:0]  r_memWData;
    logic        r_memWE;
    logic        r_memRE;

    logic        w_accept;
    logic        w_isWord;
    logic [16:0] w_lastByte;
    logic        w_outOfRange;

    // Op[1]=0 selects a word access, Op[0]=1 selects a store.
    assign w_isWord     = ~Op[1];
    assign w_lastByte   = {1'b0, Addr} + {16'b0, w_isWord};
    assign w_outOfRange = (w_lastByte >= c_MEM_BYTES);
    assign w_accept     = Req & Ready;

    assign Ready    = (r_state == S_IDLE) & ~Reset;
    assign Done     = r_done;
    assign Fault    = r_fault;
    assign LoadData = r_loadData;
    assign MemAddr  = r_memAddr;
    assign MemWData = r_memWData;
    // Strobes are masked by Reset so an interrupted access never writes.
    assign MemWE    = r_memWE & ~Reset;
    assign MemRE    = r_memRE & ~Reset;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state    <= S_IDLE;
            r_op       <= 2'b00;
            r_addr     <= 16'h0000;
            r_wdata    <= 16'h0000;
            r_done     <= 1'b0;
            r_fault    <= 1'b0;
            r_loadData <= 16'h0000;
            r_memAddr  <= 16'h0000;
            r_memWData <= 8'h00;
            r_memWE    <= 1'b0;
            r_memRE    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done  <= 1'b0;
                    r_fault <= 1'b0;
                    if (w_accept) begin
                        r_op    <= Op;
                        r_addr  <= Addr;
                        r_wdata <= WData;
                        if (w_outOfRange) begin
                            r_state    <= S_RESP;
                            r_done     <= 1'b1;
                            r_fault    <= 1'b1;
                            r_loadData <= 16'h0000;
                        end else begin
                            r_state   <= S_ACC_HI;
                            r_memAddr <= Addr;
                            if (Op[0]) begin
                                r_memWE    <= 1'b1;
                                r_memWData <= Op[1] ? WData[7:0] : WData[15:8];
                            end else begin
                                r_memRE    <= 1'b1;
                                r_memWData <= 8'h00;
                            end
                        end
                    end
                end

                S_ACC_HI: begin
                    if (!r_op[0]) begin
                        if (r_op[1]) begin
                            r_loadData <= {{8{MemRData[7]}}, MemRData};
                        end else begin
                            r_loadData <= {MemRData, r_loadData[7:0]};
                        end
                    end
                    if (!r_op[1]) begin
                        r_state    <= S_ACC_LO;
                        r_memAddr  <= r_addr + 16'd1;
                        r_memWData <= r_op[0] ? r_wdata[7:0] : 8'h00;
                    end else begin
                        r_state    <= S_RESP;
                        r_done     <= 1'b1;
                        r_fault    <= 1'b0;
                        r_memAddr  <= 16'h0000;
                        r_memWData <= 8'h00;
                        r_memWE    <= 1'b0;
                        r_memRE    <= 1'b0;
                    end
                end

                S_ACC_LO: begin
                    if (!r_op[0]) begin
                        r_loadData <= {r_loadData[15:8], MemRData};
                    end
                    r_state    <= S_RESP;
                    r_done     <= 1'b1;
                    r_fault    <= 1'b0;
                    r_memAddr  <= 16'h0000;
                    r_memWData <= 8'h00;
                    r_memWE    <= 1'b0;
                    r_memRE    <= 1'b0;
                end

                default: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_fault <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_data_mem_master.sv
// ============================================================================
//  Module   : tb_data_mem_master
//  Purpose  : Directed self-checking bench for data_mem_master with a
//             byte-wide behavioural memory.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_data_mem_master;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Req;
    logic [1:0]  Op;
    logic [15:0] Addr;
    logic [15:0] WData;
    logic        Ready;
    logic        Done;
    logic        Fault;
    logic [15:0] LoadData;
    logic [15:0] MemAddr;
    logic [7:0]  MemWData;
    logic        MemWE;
    logic        MemRE;
    logic [7:0]  MemRData;

    int checks = 0;
    int errors = 0;
    int doneCnt = 0;
    logic [23:0] weQ[$];
    logic [15:0] reQ[$];

    logic [7:0] mem [0:127];
    logic       pokeEn = 1'b0;
    logic [6:0] pokeA = 7'd0;
    logic [7:0] pokeD = 8'd0;

    data_mem_master #(.MEM_BYTES(128)) dut (
        .Clock(Clock), .Reset(Reset), .Req(Req), .Op(Op), .Addr(Addr),
        .WData(WData), .Ready(Ready), .Done(Done), .Fault(Fault),
        .LoadData(LoadData), .MemAddr(MemAddr), .MemWData(MemWData),
        .MemWE(MemWE), .MemRE(MemRE), .MemRData(MemRData)
    );

    always #5 Clock = ~Clock;

    assign MemRData = mem[MemAddr[6:0]];

    always @(posedge Clock) begin
        if (pokeEn) mem[pokeA] <= pokeD;
        else if (MemWE) mem[MemAddr[6:0]] <= MemWData;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bus monitor: strobe exclusivity and Ready never overlapping activity.
    always @(negedge Clock) begin
        if (MemWE) weQ.push_back({MemAddr, MemWData});
        if (MemRE) reQ.push_back(MemAddr);
        if (Done) doneCnt++;
        chk("bus_excl", {30'd0, MemWE & MemRE, Ready & (Done | MemWE | MemRE)}, 32'd0);
    end

    task automatic poke(input logic [6:0] a, input logic [7:0] d);
        @(negedge Clock);
        pokeEn = 1'b1; pokeA = a; pokeD = d;
        @(negedge Clock);
        pokeEn = 1'b0;
    endtask

    // Issues one request and returns with time just after the Done edge.
    task automatic doOp(input logic [1:0] op, input logic [15:0] a,
                        input logic [15:0] wd, output int lat);
        int k;
        k = 0;
        @(negedge Clock);
        while (!Ready && k < 10) begin @(negedge Clock); k++; end
        Req = 1'b1; Op = op; Addr = a; WData = wd;
        @(posedge Clock); #1;
        Req = 1'b0; Op = 2'b00; Addr = 16'h0000; WData = 16'h0000;
        lat = 1;
        while (!Done && lat < 10) begin @(posedge Clock); #1; lat++; end
    endtask

    initial begin
        int lat, s, w, d0, rdy;
        Reset = 1'b1; Req = 1'b0; Op = 2'b00; Addr = 16'h0000; WData = 16'h0000;

        poke(7'h10, 8'hAB); poke(7'h11, 8'hCD);
        poke(7'h20, 8'h00); poke(7'h21, 8'h00); poke(7'h22, 8'h22);
        poke(7'h40, 8'h80); poke(7'h41, 8'h7F);
        poke(7'h04, 8'h44); poke(7'h05, 8'h55); poke(7'h06, 8'h66);
        poke(7'h7E, 8'h9C); poke(7'h7F, 8'h7F);
        poke(7'h30, 8'h00); poke(7'h31, 8'h31);

        @(posedge Clock); #1;
        chk("rst_ready", {31'd0, Ready}, 32'd0);
        chk("rst_flags", {28'd0, Done, Fault, MemWE, MemRE}, 32'd0);
        chk("rst_load", {16'd0, LoadData}, 32'h0000);
        chk("rst_maddr", {16'd0, MemAddr}, 32'h0000);
        chk("rst_mwdata", {24'd0, MemWData}, 32'h00);
        @(negedge Clock); Reset = 1'b0; #1;
        chk("ready_after_rst", {31'd0, Ready}, 32'd1);

        // LW in range
        s = reQ.size();
        doOp(2'b00, 16'h0010, 16'h0000, lat);
        chk("lw_lat", lat, 3);
        chk("lw_data", {16'd0, LoadData}, 32'hABCD);
        chk("lw_fault", {31'd0, Fault}, 32'd0);
        chk("lw_rdcnt", reQ.size() - s, 2);
        chk("lw_addr0", {16'd0, reQ[s]}, 32'h0010);
        chk("lw_addr1", {16'd0, reQ[s+1]}, 32'h0011);

        // SW then LW
        w = weQ.size();
        doOp(2'b01, 16'h0020, 16'h1234, lat);
        chk("sw_lat", lat, 3);
        chk("sw_wecnt", weQ.size() - w, 2);
        chk("sw_wr0", {8'd0, weQ[w]}, 32'h002012);
        chk("sw_wr1", {8'd0, weQ[w+1]}, 32'h002134);
        chk("sw_keeps_load", {16'd0, LoadData}, 32'hABCD);
        doOp(2'b00, 16'h0020, 16'h0000, lat);
        chk("lw_after_sw", {16'd0, LoadData}, 32'h1234);

        // LB sign extension, SB
        doOp(2'b10, 16'h0040, 16'h0000, lat);
        chk("lb_lat", lat, 2);
        chk("lb_neg", {16'd0, LoadData}, 32'hFF80);
        doOp(2'b10, 16'h0041, 16'h0000, lat);
        chk("lb_pos", {16'd0, LoadData}, 32'h007F);
        w = weQ.size();
        doOp(2'b11, 16'h0005, 16'hBEEF, lat);
        chk("sb_lat", lat, 2);
        chk("sb_wecnt", weQ.size() - w, 1);
        chk("sb_m5", {24'd0, mem[7'h05]}, 32'hEF);
        chk("sb_m4", {24'd0, mem[7'h04]}, 32'h44);
        chk("sb_m6", {24'd0, mem[7'h06]}, 32'h66);

        // Boundaries
        doOp(2'b00, 16'h007E, 16'h0000, lat);
        chk("lw7e_fault", {31'd0, Fault}, 32'd0);
        chk("lw7e_data", {16'd0, LoadData}, 32'h9C7F);

        s = reQ.size(); w = weQ.size();
        doOp(2'b00, 16'h007F, 16'h0000, lat);
        chk("lw7f_lat", lat, 1);
        chk("lw7f_fault", {31'd0, Fault}, 32'd1);
        chk("lw7f_data", {16'd0, LoadData}, 32'h0000);
        doOp(2'b10, 16'h0080, 16'h0000, lat);
        chk("lb80_lat", lat, 1);
        chk("lb80_fault", {31'd0, Fault}, 32'd1);
        chk("lb80_data", {16'd0, LoadData}, 32'h0000);
        doOp(2'b00, 16'hFFFF, 16'h0000, lat);
        chk("lwffff_lat", lat, 1);
        chk("lwffff_fault", {31'd0, Fault}, 32'd1);
        chk("lwffff_data", {16'd0, LoadData}, 32'h0000);
        chk("fault_no_mem", (reQ.size() - s) + (weQ.size() - w), 0);

        doOp(2'b10, 16'h007F, 16'h0000, lat);
        chk("lb7f_fault", {31'd0, Fault}, 32'd0);
        chk("lb7f_data", {16'd0, LoadData}, 32'h007F);

        // Handshake with Req held high; non-Ready cycles present a stray SW
        repeat (2) @(negedge Clock);
        d0 = doneCnt;
        rdy = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clock);
            Req = 1'b1;
            if (Ready) begin
                Op = (rdy % 2 == 1) ? 2'b10 : 2'b00;
                Addr = 16'h0010;
                rdy++;
            end else begin
                Op = 2'b01; Addr = 16'h0022; WData = 16'hDEAD;
            end
        end
        @(negedge Clock);
        Req = 1'b0; Op = 2'b00; Addr = 16'h0000; WData = 16'h0000;
        repeat (6) @(negedge Clock);
        chk("hs_accepts", rdy, 6);
        chk("hs_dones", doneCnt - d0, 6);
        chk("hs_no_stray", {24'd0, mem[7'h22]}, 32'h22);

        // Reset in the ACC_LO cycle of a store
        @(negedge Clock);
        Req = 1'b1; Op = 2'b01; Addr = 16'h0030; WData = 16'hAA55;
        @(posedge Clock); #1;
        Req = 1'b0; Op = 2'b00; Addr = 16'h0000; WData = 16'h0000;
        @(posedge Clock); #1;
        d0 = doneCnt;
        Reset = 1'b1; #1;
        chk("rst_we_gated", {31'd0, MemWE}, 32'd0);
        @(posedge Clock); #1;
        Reset = 1'b0; #1;
        chk("post_rst_ready", {31'd0, Ready}, 32'd1);
        chk("post_rst_flags", {28'd0, Done, Fault, MemWE, MemRE}, 32'd0);
        chk("post_rst_load", {16'd0, LoadData}, 32'h0000);
        chk("post_rst_maddr", {16'd0, MemAddr}, 32'h0000);
        chk("post_rst_mwdata", {24'd0, MemWData}, 32'h00);
        chk("rst_m30", {24'd0, mem[7'h30]}, 32'hAA);
        chk("rst_m31", {24'd0, mem[7'h31]}, 32'h31);
        repeat (4) @(negedge Clock);
        chk("rst_no_done", doneCnt - d0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
